// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the unified-memory arbiter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_WAIT = 2'd2} state_e;
   typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;
   localparam logic [1:0] MEM_RD = 2'b10;
   localparam logic [1:0] MEM_WR = 2'b01;
   localparam int CNT_W = 3;
endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// mem_lat_counter: load/decrement counter with zero flag that times RAM read latency.
module mem_lat_counter
   import mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clk)
      cnt_q <= rst ? '0 : load_i ? val_i : dec_i ? cnt_q - CNT_W'(1) : cnt_q;
   assign cnt_o  = cnt_q;
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one single-port RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1,
   parameter int I_BASE = 0
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic [1:0]        mem_ctrl,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_e            state_q, state_d;
   gnt_e              who_q, who_d;
   logic              we_q, we_d, i_ack_q, i_ack_d, d_ack_q, d_ack_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              grant_data, done, cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]  cnt;

`ifdef MEM_ARB_RR_EN
   gnt_e last_q;
   assign grant_data = d_req && (!i_req || last_q == GNT_I);
   always_ff @(posedge CLK)
      last_q <= rst ? GNT_D : (state_q == ST_IDLE && (i_req || d_req)) ? (grant_data ? GNT_D : GNT_I) : last_q;
`else
   assign grant_data = d_req;
`endif

   mem_lat_counter u_cnt (
      .clk   (CLK),
      .rst   (rst),
      .load_i(cnt_load),
      .dec_i (cnt_dec),
      .val_i (CNT_W'(RD_LAT - 1)),
      .cnt_o (cnt),
      .zero_o(cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      who_d    = who_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ctrl_d   = 2'b00;
      done     = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         ST_IDLE: if (i_req || d_req) begin
            state_d = ST_ACCESS;
            who_d   = grant_data ? GNT_D : GNT_I;
            we_d    = grant_data && d_we;
            addr_d  = grant_data ? d_addr : i_addr + ADDR_W'(I_BASE);
            wdata_d = grant_data ? d_wdata : wdata_q;
            ctrl_d  = (grant_data && d_we) ? MEM_WR : MEM_RD;
         end
         ST_ACCESS: begin
            state_d  = ST_WAIT;
            cnt_load = !we_q;
            done     = we_q || (RD_LAT == 1);
         end
         ST_WAIT: begin
            state_d = (i_ack_q || d_ack_q) ? ST_IDLE : ST_WAIT;
            cnt_dec = !cnt_zero;
            // ack is registered, so it is raised one cycle before the counter hits zero
            done    = !(i_ack_q || d_ack_q) && cnt == CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      i_ack_d = done && who_q == GNT_I;
      d_ack_d = done && who_q == GNT_D;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= ST_IDLE;
         who_q   <= GNT_D;
         we_q    <= 1'b0;
         ctrl_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         who_q   <= who_d;
         we_q    <= we_d;
         ctrl_q  <= ctrl_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         i_ack_q <= i_ack_d;
         d_ack_q <= d_ack_d;
      end
   end

   assign mem_ctrl  = ctrl_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: four arbiters (RD_LAT 1..4, I_BASE 0xC0) on shared stimulus,
// each checked every cycle against a schedule-based model, plus literal pins.
module tb_mem_arbiter;
   logic       clk = 1'b0;
   logic       rst, i_req, d_req, d_we;
   logic [7:0] i_addr, d_addr, d_wdata;
   int         n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input int n);
      repeat (n) begin
         tick();
         i_req = 1'b0;
         d_req = 1'b0;
         d_we  = 1'b0;
      end
   endtask

   genvar g;
   for (g = 0; g < 4; g++) begin : lat
      localparam int L = g + 1;
      logic [7:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
      logic       i_ack, d_ack;
      logic [1:0] mem_ctrl;
      bit   [7:0] ram [256];
      bit         vld [256];
      bit   [7:0] pipe [4];

      mem_arbiter #(.DATA_W(8), .ADDR_W(8), .RD_LAT(L), .I_BASE(8'hC0)) dut (
         .CLK(clk), .rst(rst),
         .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
         .d_rdata(d_rdata), .d_ack(d_ack),
         .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
      );

      // RAM: unwritten locations read as addr^0x85; read data emerges L cycles after the strobe
      assign mem_rdata = pipe[L-1];
      always @(posedge clk) begin
         if (mem_ctrl[0]) begin
            ram[mem_addr] <= mem_wdata;
            vld[mem_addr] <= 1'b1;
         end
         pipe[0] <= vld[mem_addr] ? ram[mem_addr] : mem_addr ^ 8'h85;
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end

      bit   [7:0] sh [256];
      int         c, strobe, ack, free;
      bit         pd, wr, last_d, r, ir, dr, dwe;
      logic [7:0] ea, ew, er, ia, da, dw;

      initial begin
         c = 0; strobe = -1; ack = -1; free = 0;
         pd = 1'b0; wr = 1'b0; last_d = 1'b1; ea = 8'h00; ew = 8'h00; er = 8'h00;
         for (int a = 0; a < 256; a++) sh[a] = 8'(a) ^ 8'h85;
         forever begin
            @(posedge clk);
            r = rst; ir = i_req; dr = d_req; dwe = d_we; ia = i_addr; da = d_addr; dw = d_wdata;
            if (r) begin
               free = c + 1; strobe = -1; ack = -1; ea = 8'h00; ew = 8'h00; last_d = 1'b1;
            end else if (c >= free && (ir || dr)) begin
`ifdef MEM_ARB_RR_EN
               pd = dr && (!ir || !last_d);
`else
               pd = dr;
`endif
               last_d = pd;
               wr = pd && dwe;
               ea = pd ? da : ia + 8'hC0;
               if (pd) ew = dw;
               er = sh[ea];
               if (wr) sh[ea] = dw;
               strobe = c + 1;
               ack = wr ? c + 2 : c + 1 + L;
               free = ack + 1;
            end
            c++;
            @(negedge clk);
            chk($sformatf("L%0d mem_ctrl cyc%0d", L, c), 32'(mem_ctrl), 32'(c == strobe ? (wr ? 2'b01 : 2'b10) : 2'b00));
            chk($sformatf("L%0d mem_addr cyc%0d", L, c), 32'(mem_addr), 32'(ea));
            chk($sformatf("L%0d mem_wdata cyc%0d", L, c), 32'(mem_wdata), 32'(ew));
            chk($sformatf("L%0d i_ack cyc%0d", L, c), 32'(i_ack), 32'(c == ack && !pd));
            chk($sformatf("L%0d d_ack cyc%0d", L, c), 32'(d_ack), 32'(c == ack && pd));
            if (c == ack && !wr)
               chk($sformatf("L%0d rdata cyc%0d", L, c), 32'(pd ? d_rdata : i_rdata), 32'(er));
         end
      end
   end

   typedef struct {bit ir, dr, we; bit [7:0] ia, da, wd;} vec_t;
   vec_t  tbl [6];
   int    cnt [4], last [4];
   bit    ak [4], dk [4];
   string ord, exp_ord;

   initial begin
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset mem_ctrl", 32'(lat[1].mem_ctrl), 32'h0);
      chk("reset mem_addr", 32'(lat[1].mem_addr), 32'h0);
      chk("reset acks", 32'({lat[1].i_ack, lat[1].d_ack}), 32'h0);
      quiet(2);
      // read 0x20 at RD_LAT=2
      tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      tick(); d_req = 1'b0;
      @(negedge clk); chk("rd strobe", 32'(lat[1].mem_ctrl), 32'h2); chk("rd ack early1", 32'(lat[1].d_ack), 32'h0);
      tick(); @(negedge clk); chk("rd ack early2", 32'(lat[1].d_ack), 32'h0);
      tick(); @(negedge clk); chk("rd ack", 32'(lat[1].d_ack), 32'h1); chk("rd data", 32'(lat[1].d_rdata), 32'hA5);
      tick(); @(negedge clk); chk("rd ack late", 32'(lat[1].d_ack), 32'h0);
      quiet(8);
      // write 0x3C to 0x07, then read it back
      tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h07; d_wdata = 8'h3C;
      tick(); d_req = 1'b0; d_we = 1'b0;
      @(negedge clk); chk("wr strobe", 32'(lat[1].mem_ctrl), 32'h1); chk("wr wdata", 32'(lat[1].mem_wdata), 32'h3C);
      tick(); @(negedge clk); chk("wr ack L2", 32'(lat[1].d_ack), 32'h1); chk("wr ack L4", 32'(lat[3].d_ack), 32'h1);
      quiet(8);
      tick(); d_req = 1'b1; d_addr = 8'h07;
      tick(); d_req = 1'b0;
      tick(); tick(); @(negedge clk);
      chk("rdback ack", 32'(lat[1].d_ack), 32'h1); chk("rdback data", 32'(lat[1].d_rdata), 32'h3C);
      quiet(8);
      // fetch with wrapping base offset
      tick(); i_req = 1'b1; i_addr = 8'h50;
      tick(); i_req = 1'b0;
      @(negedge clk); chk("fetch addr wrap", 32'(lat[1].mem_addr), 32'h10); chk("fetch strobe", 32'(lat[1].mem_ctrl), 32'h2);
      tick(); tick(); @(negedge clk);
      chk("fetch ack", 32'(lat[1].i_ack), 32'h1); chk("fetch data", 32'(lat[1].i_rdata), 32'h95);
      quiet(8);
      // mixed directed vectors, model-checked
      tbl = '{'{1, 1, 1, 8'hFF, 8'hFF, 8'h11}, '{1, 0, 0, 8'h3F, 8'h00, 8'h00},
              '{0, 1, 0, 8'h00, 8'hFF, 8'h00}, '{1, 1, 0, 8'h47, 8'h20, 8'h00},
              '{0, 1, 1, 8'h00, 8'h00, 8'hEE}, '{1, 0, 0, 8'h40, 8'h00, 8'h00}};
      foreach (tbl[v]) begin
         tick();
         i_req = tbl[v].ir; d_req = tbl[v].dr; d_we = tbl[v].we;
         i_addr = tbl[v].ia; d_addr = tbl[v].da; d_wdata = tbl[v].wd;
         quiet(8);
      end
      // continuous contention from reset: grant order and back-to-back spacing
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      tick(); i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 8'h01; d_addr = 8'h02;
      ord = "";
      for (int k = 0; k < 4; k++) begin cnt[k] = 0; last[k] = 0; end
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         ak = '{lat[0].i_ack, lat[1].i_ack, lat[2].i_ack, lat[3].i_ack};
         dk = '{lat[0].d_ack, lat[1].d_ack, lat[2].d_ack, lat[3].d_ack};
         for (int k = 0; k < 4; k++) if (ak[k] || dk[k]) begin
            if (cnt[k] > 0 && cnt[k] < 4) chk($sformatf("L%0d ack spacing", k + 1), 32'(n - last[k]), 32'(k + 3));
            if (k == 1 && cnt[k] < 4) ord = {ord, dk[k] ? "D" : "I"};
            last[k] = n;
            cnt[k]++;
         end
         if (cnt[0] >= 4 && cnt[1] >= 4 && cnt[2] >= 4 && cnt[3] >= 4) break;
         tick();
      end
      for (int k = 0; k < 4; k++) chk($sformatf("L%0d four acks in budget", k + 1), 32'(cnt[k] >= 4), 32'h1);
`ifdef MEM_ARB_RR_EN
      exp_ord = "IDID";
`else
      exp_ord = "DDDD";
`endif
      n_cmp++;
      if (ord != exp_ord) begin
         n_bad++;
         $display("FAIL grant order: got %s, expected %s", ord, exp_ord);
      end
      quiet(10);
      // reset during the WAIT of an RD_LAT=4 read, then a fresh read
      tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 8'h33;
      tick(); d_req = 1'b0;
      tick();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; d_req = 1'b1; d_addr = 8'h34;
      @(negedge clk); chk("post-rst mem_ctrl", 32'(lat[3].mem_ctrl), 32'h0); chk("post-rst d_ack", 32'(lat[3].d_ack), 32'h0);
      tick(); d_req = 1'b0;
      @(negedge clk); chk("post-rst strobe", 32'(lat[3].mem_ctrl), 32'h2); chk("abandoned ack", 32'(lat[3].d_ack), 32'h0);
      chk("post-rst addr", 32'(lat[3].mem_addr), 32'h34);
      repeat (3) begin
         tick(); @(negedge clk); chk("no stray ack", 32'(lat[3].d_ack), 32'h0);
      end
      tick(); @(negedge clk);
      chk("new read ack", 32'(lat[3].d_ack), 32'h1); chk("new read data", 32'(lat[3].d_rdata), 32'hB1);
      quiet(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised unified-memory arbiter. One single-port synchronous RAM serves both instruction-fetch and data-access ports of the core, replacing the fixed 8-bit split IRAM/DRAM arrangement.
- Sits between the register/core wrapper and the RAM inside the processor top.
- Serialises fetch and load/store requests, relocates fetch addresses by a base offset, and hides configurable RAM read latency behind a req/ack handshake.

Parameters:
- DATA_W, 8, data bus width in bits.
- ADDR_W, 8, address width in bits.
- RD_LAT, 1, RAM read latency in cycles (legal 1..4).
- I_BASE, 0, offset added to instruction addresses, modulo 2^ADDR_W.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request; held until i_ack.
- i_addr  input  ADDR_W  fetch address, pre-offset.
- i_rdata  output  DATA_W  fetch data; valid only while i_ack=1.
- i_ack  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1=write, 0=read; held with d_req.
- d_addr  input  ADDR_W  data address, unmodified.
- d_wdata  input  DATA_W  write data.
- d_rdata  output  DATA_W  load data; valid only while d_ack=1.
- d_ack  output  1  one-cycle data completion pulse.
- mem_ctrl  output  2  bit1=read strobe, bit0=write strobe (MEMCtrl encoding).
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM q, valid RD_LAT cycles after the read strobe.

Behaviour:
- Reset: state IDLE; i_ack, d_ack, mem_ctrl, mem_addr, mem_wdata and the latency counter are 0; last_grant=D. i_rdata/d_rdata are don't-care while their ack is 0.
- Reset mid-access: the in-flight access is abandoned with no ack. State is IDLE the cycle after rst deasserts.
- FSM IDLE -> ACCESS -> WAIT -> IDLE. All outputs are registered except i_rdata/d_rdata, which are wires from mem_rdata.
- IDLE (cycle G):
  - Samples requests.
  - If any are pending, picks the grantee and registers mem_addr, mem_wdata and mem_ctrl (read 2'b10, write 2'b01).
  - Goes to ACCESS.
- ACCESS (cycle T=G+1):
  - The strobe is high for this one cycle only.
  - A write goes to WAIT with its ack set for T+1.
  - A read loads counter=RD_LAT-1.
- WAIT:
  - The read waits until the counter reaches 0; the ack is high in cycle T+RD_LAT.
  - The write ack is high in cycle T+1.
  - The state returns to IDLE after the ack cycle.
- Latency from req to ack: read 1+RD_LAT cycles; write 2 cycles. Throughput is at most one access every RD_LAT+2 cycles for reads and every 3 cycles for writes.
- mem_addr and mem_wdata hold their last values outside the strobe cycle. mem_ctrl is 2'b00 outside T; 2'b11 never occurs.
- Fetch address: mem_addr = (i_addr + I_BASE) truncated to ADDR_W, wrapping with no flag. Data address passes through unchanged.
- Arbitration without the feature: fixed priority, data over fetch.
- Requesters must drop req in the cycle after ack, otherwise it is a new request. If a req is dropped before ack, the access still completes and acks.
- i_ack and d_ack are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When i_req and d_req are both pending in IDLE, grant the port not recorded in last_grant; last_grant updates on every grant. A lone request is always granted.
- Undefined: fixed data priority. last_grant is not implemented and fetch may starve under continuous d_req.

Decomposition:
- Shared package or define file holds:
  - state encodings ST_IDLE/ST_ACCESS/ST_WAIT;
  - MEM_RD=2'b10 and MEM_WR=2'b01;
  - port IDs GNT_I/GNT_D.
- One natural sub-module: mem_lat_counter. It is a 3-bit load/decrement counter with a zero flag, loaded with RD_LAT-1.

Test Plan:
- RD_LAT=2: d_req=1, d_we=0, d_addr=8'h20 in cycle 0, RAM[0x20]=8'hA5 -> mem_ctrl=2'b10 in cycle 1; d_ack=1 and d_rdata=8'hA5 in cycle 3 only.
- d_req, d_we=1, d_addr=8'h07, d_wdata=8'h3C -> mem_ctrl=2'b01 and mem_wdata=8'h3C in cycle 1; d_ack in cycle 2. A following read of 0x07 returns 8'h3C.
- I_BASE=8'hC0, i_addr=8'h50 -> mem_addr=8'h10 in the strobe cycle (wrap). i_ack is high 1+RD_LAT cycles after the request.
- i_req and d_req held continuously for 4 grants -> without the macro: order D,D,D,D. With MEM_ARB_RR_EN: order I,D,I,D from reset (last_grant=D).
- rst pulsed in a WAIT cycle of an RD_LAT=4 read -> no ack ever issued; mem_ctrl=0 and state IDLE after reset. A new read then completes normally.
- Varied RD_LAT from 1 to 4 with back-to-back reads -> acks spaced exactly RD_LAT+2 cycles apart; never two acks in one cycle.
